instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Front-end stage of the RV32I pipeline, directly upstream of the instruction decoders (R/I/S/B/U/J).
- Owns the PC and issues single-outstanding word fetches to instruction memory via a valid/ready request and valid response.
- Presents {pc, instruction, pc+4} to decode through an IF/ID output register with stall and flush.
- Accepts redirects (jump/branch targets) from execute and discards any wrong-path fetch in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on if_instr when if_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid; at most one per accepted request, ≥1 cycle after acceptance
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  flush pipeline front and restart at redirect_pc
- redirect_pc  in  32  new PC; bits[1:0] ignored (treated as 0)
- stall  in  1  decode cannot accept; hold IF/ID register
- if_valid  out  1  IF/ID register holds a valid instruction
- if_pc  out  32  PC of if_instr
- if_instr  out  32  instruction to decoders
- if_pc_plus4  out  32  if_pc + 4 (link value for JAL/JALR)

Behaviour:
- Clock/reset decided: one clock clk; reset rst_n asynchronous, active-low.
- Reset values: pc=RESET_PC; state=S_REQ; kill=0; if_valid=0; if_pc=0; if_instr=NOP_INSTR; if_pc_plus4=0. imem_req_valid is 0 during reset and rises on the first clock after deassertion.
- FSM has 3 states: S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Handshake (valid&&ready) -> S_WAIT.
  - imem_req_addr stays stable until handshake, unless a redirect arrives.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill=1: drop data, clear kill, -> S_REQ.
  - On imem_rsp_valid with kill=0 and the output slot free (!if_valid || !stall): load if_pc=pc, if_instr=data, if_pc_plus4=pc+4, if_valid=1; pc<=pc+4; -> S_REQ.
  - Output slot busy: store data in a 32-bit hold buffer, -> S_HOLD.
- S_HOLD:
  - imem_req_valid=0.
  - When stall=0: move buffer to the output register (pc/pc+4 as above), pc<=pc+4, -> S_REQ.
- Output register: if stall=0 and no new load this cycle, if_valid<=0 and if_instr<=NOP_INSTR. If stall=1, all if_* hold.
- Best-case throughput: one instruction every 2 cycles for 1-cycle memory latency. Request-to-if_valid latency is response latency + 1 cycle.
- Redirect has priority over everything except reset, including stall:
  - Always: pc<={redirect_pc[31:2],2'b00}; if_valid<=0 and if_instr<=NOP_INSTR on the next edge.
  - S_REQ, no handshake this cycle: stay S_REQ; address switches to the new PC next cycle.
  - S_REQ with handshake this same cycle: -> S_WAIT with kill=1.
  - S_WAIT, response not arriving this cycle: kill<=1 and stay S_WAIT.
  - S_WAIT, response arriving this same cycle: drop it, -> S_REQ.
  - S_HOLD: drop buffer, -> S_REQ.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Reset mid-transaction: state and kill clear immediately. A stale response arriving after reset release must never reach if_valid; the memory is required to be reset alongside this block.

Decomposition:
- Shared include (inc/, alongside alu_opcode.v) holds:
  - RV32 NOP constant (32'h0000_0013).
  - IF FSM state encodings (S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2).
- One natural sub-module: fetch_pc_gen. It holds the PC register, +4 incrementer and redirect mux, with an advance/redirect input and pc / pc_plus4 outputs. The FSM and IF/ID register stay in instr_fetch_unit.

Test Plan:
- Reset release, memory always ready, 1-cycle response, rsp_data=addr^32'hA5A5_0000 -> requests at 0x0,0x4,0x8 on every second cycle; if_pc 0x0/0x4/0x8 with matching if_instr; if_pc_plus4 = if_pc+4.
- stall=1 held 3 cycles while a response for 0x8 arrives -> if_* frozen at 0x4; 0x8 buffered in S_HOLD; no new request. After stall=0 -> if_pc=0x8 next cycle, then request 0xC.
- redirect_valid with redirect_pc=0x100 while in S_WAIT for 0xC, response 2 cycles later -> that response is discarded; next request addr=0x100; first valid if_pc=0x100; if_valid=0 in between.
- redirect and imem_rsp_valid in the same cycle, redirect_pc=0x203 -> response dropped; next request addr=0x200.
- redirect with stall=1 and if_valid=1 -> if_valid=0 next edge despite stall.
- PC=0xFFFF_FFFC fetch completes -> next request addr=0x0000_0000; rst_n asserted mid-S_WAIT -> if_valid=0, if_instr=0x13, addr=RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the RV32I instruction fetch front-end.
package instr_fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with +4 incrementer and redirect mux.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  logic [31:0] pc_q;
  logic        unused_lsbs;

  // Targets are always word aligned; the low bits are dropped.
  assign unused_lsbs = ^redirect_pc[1:0];

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;

  // PC update: redirect wins over sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (advance) begin
      pc_q <= pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem fetch FSM feeding an IF/ID register.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = RV32_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4
);

  if_state_e   state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_q, hold_d;
  logic        req_en_q;
  logic        req_fire;
  logic        slot_free;
  logic        load;
  logic [31:0] load_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (load),
    .redirect    (redirect_valid),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  // Requests are held off until the first clock after reset release.
  assign imem_req_valid = req_en_q && (state_q == S_REQ);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign slot_free      = !if_valid || !stall;

  // Next-state logic; a redirect kills or drops whatever is in flight.
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_data = hold_q;
    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
          kill_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (slot_free) begin
            load      = 1'b1;
            load_data = imem_rsp_data;
            state_d   = S_REQ;
          end else begin
            hold_d  = imem_rsp_data;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          state_d = S_REQ;
        end else if (!stall) begin
          load    = 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // FSM, kill flag, hold buffer and request enable registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      kill_q   <= 1'b0;
      hold_q   <= 32'h0;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      hold_q   <= hold_d;
      req_en_q <= 1'b1;
    end
  end

  // IF/ID register: redirect flushes even under stall; otherwise stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_instr    <= NOP_INSTR;
      if_pc_plus4 <= 32'h0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (load) begin
      if_valid    <= 1'b1;
      if_pc       <= pc;
      if_instr    <= load_data;
      if_pc_plus4 <= pc_plus4;
    end else if (!stall) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

endmodule
